// File: rtl/rw_pkg.sv
// Shared types for the stateful-register control-plane reader.
//   rw_state_e   : reader FSM states (IDLE -> READ -> RESP -> IDLE)
//   state_word_t : one state register at the default width
package rw_pkg;
  localparam int DEF_COUNT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } rw_state_e;

  typedef logic [DEF_COUNT_WIDTH-1:0] state_word_t;
endpackage

// File: rtl/rw_state_array.sv
// Array of state registers.
//   clk, rst_n          : clock, async active-low reset (entries -> 0)
//   wr_en/wr_index/wr_data : packet write port; out-of-range index matches no entry
//   clr_en/clr_index    : zero one entry; loses to a same-cycle write
//   rd_index/rd_data    : combinational read, 0 for out-of-range index
module rw_state_array #(
  parameter int COUNT_WIDTH = 32,
  parameter int NUM_ENTRIES = 16,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_index,
  input  logic [COUNT_WIDTH-1:0] wr_data,
  input  logic                   clr_en,
  input  logic [INDEX_WIDTH-1:0] clr_index,
  input  logic [INDEX_WIDTH-1:0] rd_index,
  output logic [COUNT_WIDTH-1:0] rd_data
);
  logic [NUM_ENTRIES-1:0][COUNT_WIDTH-1:0] mem;

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem[i] <= '0;
      end else if (wr_en && (wr_index == INDEX_WIDTH'(i))) begin
        mem[i] <= wr_data;
      end else if (clr_en && (clr_index == INDEX_WIDTH'(i))) begin
        mem[i] <= '0;
      end
    end
  end

  // Match-and-select read keeps out-of-range indices from touching the array.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (rd_index == INDEX_WIDTH'(i)) rd_data = mem[i];
    end
  end
endmodule

// File: rtl/rw_state_reader.sv
// Control-plane read side of the stateful register atoms.
//   clk, rst_n                       : clock, async active-low reset
//   i__wr_valid/i__wr_index/i__wr_data : packet-side writes, any state
//   i__req_valid/o__req_ready/i__req_index : read request handshake
//   o__rsp_valid/i__rsp_ready/o__rsp_data/o__rsp_err : read response handshake
//   o__rd_count                      : completed reads, wraps
// One read per IDLE -> READ -> RESP round trip. The array is sampled in READ,
// so a write in the accept cycle is seen and a write in READ is not.
module rw_state_reader
  import rw_pkg::*;
#(
  parameter int COUNT_WIDTH   = DEF_COUNT_WIDTH,
  parameter int NUM_ENTRIES   = 16,
  parameter int INDEX_WIDTH   = 4,
  parameter bit CLEAR_ON_READ = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i__wr_valid,
  input  logic [INDEX_WIDTH-1:0] i__wr_index,
  input  logic [COUNT_WIDTH-1:0] i__wr_data,
  input  logic                   i__req_valid,
  output logic                   o__req_ready,
  input  logic [INDEX_WIDTH-1:0] i__req_index,
  output logic                   o__rsp_valid,
  input  logic                   i__rsp_ready,
  output logic [COUNT_WIDTH-1:0] o__rsp_data,
  output logic                   o__rsp_err,
  output logic [COUNT_WIDTH-1:0] o__rd_count
);
  rw_state_e              state_q, state_d;
  logic [INDEX_WIDTH-1:0] idx_q;
  logic [COUNT_WIDTH-1:0] arr_rd;
  logic                   in_range;
  logic                   accept;
  logic                   rsp_hs;
  logic                   clr;

  assign in_range = {1'b0, idx_q} < (INDEX_WIDTH+1)'(NUM_ENTRIES);
  // Gate with rst_n so the requester never sees ready while held in reset.
  assign o__req_ready = (state_q == IDLE) && rst_n;
  assign accept       = i__req_valid && o__req_ready;
  assign rsp_hs       = (state_q == RESP) && i__rsp_ready;
  assign clr          = CLEAR_ON_READ && (state_q == READ) && in_range;

  rw_state_array #(
    .COUNT_WIDTH(COUNT_WIDTH),
    .NUM_ENTRIES(NUM_ENTRIES),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (i__wr_valid),
    .wr_index (i__wr_index),
    .wr_data  (i__wr_data),
    .clr_en   (clr),
    .clr_index(idx_q),
    .rd_index (idx_q),
    .rd_data  (arr_rd)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    state_d = RESP;
      RESP:    if (i__rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      o__rsp_valid <= 1'b0;
      o__rsp_data  <= '0;
      o__rsp_err   <= 1'b0;
      o__rd_count  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) idx_q <= i__req_index;
      if (state_q == READ) begin
        o__rsp_valid <= 1'b1;
        o__rsp_data  <= in_range ? arr_rd : '0;
        o__rsp_err   <= !in_range;
      end
      if (rsp_hs) begin
        o__rsp_valid <= 1'b0;
        o__rd_count  <= o__rd_count + COUNT_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_rw_state_reader.sv
// Scoreboard bench: two instances (plain and clear-on-read), 5-bit index so
// out-of-range reads/writes are reachable with 16 entries.
module tb_rw_state_reader;
  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic clk;
  logic rst_n;
  logic        wr_valid  [2];
  logic [4:0]  wr_index  [2];
  logic [31:0] wr_data   [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic [4:0]  req_index [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_data  [2];
  logic        rsp_err   [2];
  logic [31:0] rd_count  [2];

  exp_t q0[$];
  exp_t q1[$];
  int vectors = 0;
  int errors  = 0;

  rw_state_reader #(.COUNT_WIDTH(32), .NUM_ENTRIES(16), .INDEX_WIDTH(5), .CLEAR_ON_READ(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .i__wr_valid(wr_valid[0]), .i__wr_index(wr_index[0]), .i__wr_data(wr_data[0]),
    .i__req_valid(req_valid[0]), .o__req_ready(req_ready[0]), .i__req_index(req_index[0]),
    .o__rsp_valid(rsp_valid[0]), .i__rsp_ready(rsp_ready[0]), .o__rsp_data(rsp_data[0]),
    .o__rsp_err(rsp_err[0]), .o__rd_count(rd_count[0])
  );

  rw_state_reader #(.COUNT_WIDTH(32), .NUM_ENTRIES(16), .INDEX_WIDTH(5), .CLEAR_ON_READ(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i__wr_valid(wr_valid[1]), .i__wr_index(wr_index[1]), .i__wr_data(wr_data[1]),
    .i__req_valid(req_valid[1]), .o__req_ready(req_ready[1]), .i__req_index(req_index[1]),
    .o__rsp_valid(rsp_valid[1]), .i__rsp_ready(rsp_ready[1]), .o__rsp_data(rsp_data[1]),
    .o__rsp_err(rsp_err[1]), .o__rd_count(rd_count[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs change at posedge, bench inputs at posedge+2, so negedge is quiet.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int s = 0; s < 2; s++) begin
        if (rsp_valid[s]) begin
          if ((s == 0 ? q0.size() : q1.size()) == 0) begin
            chk($sformatf("dut%0d unexpected rsp", s), 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = (s == 0) ? q0[0] : q1[0];
            chk($sformatf("dut%0d rsp_data", s), rsp_data[s], e.d);
            chk($sformatf("dut%0d rsp_err", s), 32'(rsp_err[s]), 32'(e.e));
            chk($sformatf("dut%0d req_ready busy", s), 32'(req_ready[s]), 32'd0);
            if (rsp_ready[s]) begin
              if (s == 0) void'(q0.pop_front());
              else        void'(q1.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic wr(input int s, input int idx, input logic [31:0] d);
    wr_valid[s] = 1'b1;
    wr_index[s] = 5'(idx);
    wr_data[s]  = d;
    @(posedge clk); #2;
    wr_valid[s] = 1'b0;
  endtask

  // Drives the request through the accept edge; returns in the READ cycle.
  task automatic issue(input int s, input int idx, input logic [31:0] ed, input logic ee,
                       input bit w, input logic [31:0] wd);
    exp_t e;
    e.d = ed;
    e.e = ee;
    if (s == 0) q0.push_back(e); else q1.push_back(e);
    chk("req_ready idle", 32'(req_ready[s]), 32'd1);
    req_valid[s] = 1'b1;
    req_index[s] = 5'(idx);
    if (w) begin
      wr_valid[s] = 1'b1;
      wr_index[s] = 5'(idx);
      wr_data[s]  = wd;
    end
    @(posedge clk); #2;
    req_valid[s] = 1'b0;
    wr_valid[s]  = 1'b0;
    chk("rsp_valid in READ", 32'(rsp_valid[s]), 32'd0);
    chk("req_ready in READ", 32'(req_ready[s]), 32'd0);
  endtask

  task automatic finish(input int s, input int stall, input int cnt);
    @(posedge clk); #2;
    wr_valid[s] = 1'b0;
    chk("rsp_valid latency", 32'(rsp_valid[s]), 32'd1);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #2;
    end
    rsp_ready[s] = 1'b1;
    @(posedge clk); #2;
    rsp_ready[s] = 1'b0;
    chk("rsp_valid after hs", 32'(rsp_valid[s]), 32'd0);
    chk("req_ready after hs", 32'(req_ready[s]), 32'd1);
    chk("rd_count", rd_count[s], 32'(cnt));
  endtask

  task automatic rd(input int s, input int idx, input logic [31:0] ed, input logic ee,
                    input int stall, input int cnt);
    issue(s, idx, ed, ee, 1'b0, 32'd0);
    finish(s, stall, cnt);
  endtask

  initial begin
    rst_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      wr_valid[s] = 1'b0; wr_index[s] = '0; wr_data[s] = '0;
      req_valid[s] = 1'b0; req_index[s] = '0; rsp_ready[s] = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("reset rsp_valid", 32'(rsp_valid[s]), 32'd0);
      chk("reset rsp_data", rsp_data[s], 32'd0);
      chk("reset rsp_err", 32'(rsp_err[s]), 32'd0);
      chk("reset rd_count", rd_count[s], 32'd0);
      chk("reset req_ready", 32'(req_ready[s]), 32'd0);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Basic read, then stalled read.
    wr(0, 3, 32'h1234);
    rd(0, 3, 32'h1234, 1'b0, 0, 1);
    rd(0, 3, 32'h1234, 1'b0, 5, 2);

    // Accept-cycle write is seen, READ-cycle write is not but lands.
    issue(0, 5, 32'hAA, 1'b0, 1'b1, 32'hAA);
    wr_valid[0] = 1'b1; wr_index[0] = 5'd5; wr_data[0] = 32'hBB;
    finish(0, 0, 3);
    rd(0, 5, 32'hBB, 1'b0, 0, 4);

    // Out-of-range read and write.
    rd(0, 20, 32'h0, 1'b1, 0, 5);
    wr(0, 20, 32'hDEAD);
    rd(0, 3, 32'h1234, 1'b0, 0, 6);
    rd(0, 5, 32'hBB, 1'b0, 0, 7);
    rd(0, 20, 32'h0, 1'b1, 0, 8);
    rd(0, 4, 32'h0, 1'b0, 0, 9);

    // Clear-on-read, then write-beats-clear.
    wr(1, 2, 32'd7);
    rd(1, 2, 32'd7, 1'b0, 0, 1);
    rd(1, 2, 32'd0, 1'b0, 0, 2);
    wr(1, 2, 32'd7);
    issue(1, 2, 32'd7, 1'b0, 1'b0, 32'd0);
    wr_valid[1] = 1'b1; wr_index[1] = 5'd2; wr_data[1] = 32'd9;
    finish(1, 0, 3);
    rd(1, 2, 32'd9, 1'b0, 0, 4);

    // Reset during RESP drops the response and clears everything.
    issue(0, 3, 32'h1234, 1'b0, 1'b0, 32'd0);
    @(posedge clk); #2;
    chk("rsp_valid before reset", 32'(rsp_valid[0]), 32'd1);
    rst_n = 1'b0;
    q0.delete();
    #1;
    chk("mid reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("mid reset req_ready", 32'(req_ready[0]), 32'd0);
    chk("mid reset rd_count", rd_count[0], 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("post reset req_ready", 32'(req_ready[0]), 32'd1);
    chk("post reset rd_count", rd_count[0], 32'd0);
    @(posedge clk); #2;
    rd(0, 3, 32'h0, 1'b0, 0, 1);
    rd(0, 5, 32'h0, 1'b0, 0, 2);
    rd(1, 2, 32'h0, 1'b0, 0, 1);

    chk("q0 drained", 32'(q0.size()), 32'd0);
    chk("q1 drained", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
